// File: rtl/fp_pipe_scoreboard.sv
// fp_pipe_scoreboard
// -------------------
// Scoreboard for the FPU pipeline. It records the destination register and
// write enable of the FP instruction held in each of the stages E1, E2, E3
// and W. Each cycle it compares the sources of the instruction in IU decode
// against those stages. From that comparison it produces stall and
// forwarding controls. It also holds an fdiv/fsqrt in E1 for the extra
// cycles the divider needs.
//
// Ports:
//   clk, clrn                  pipeline clock, asynchronous active-low reset
//   id_valid                   decode holds a valid FP-arith instruction
//   id_fc                      FP operation code
//   id_fs, id_ft               source registers a / b
//   id_use_fs, id_use_ft       instruction reads fs / ft (ft includes swc1 data)
//   id_fd, id_wf               destination register and its write enable
//   e1n/e2n/e3n/wn             destination register per stage
//   e1w/e2w/e3w/ww             write enable per stage
//   fwdfa, fwdfb               select the E3 result for operand a / b
//   stl_fp, stl_div, stl       data-hazard stall, divider-busy stall, and their OR
//   div_cnt                    remaining extra divider cycles (debug)
module fp_pipe_scoreboard #(
  parameter int          DIV_CYCLES = 4,
  parameter logic [2:0]  FC_DIV     = 3'b011,
  parameter logic [2:0]  FC_SQRT    = 3'b111
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       id_valid,
  input  logic [2:0] id_fc,
  input  logic [4:0] id_fs,
  input  logic [4:0] id_ft,
  input  logic       id_use_fs,
  input  logic       id_use_ft,
  input  logic [4:0] id_fd,
  input  logic       id_wf,
  output logic [4:0] e1n,
  output logic [4:0] e2n,
  output logic [4:0] e3n,
  output logic [4:0] wn,
  output logic       e1w,
  output logic       e2w,
  output logic       e3w,
  output logic       ww,
  output logic       fwdfa,
  output logic       fwdfb,
  output logic       stl_fp,
  output logic       stl_div,
  output logic       stl,
  output logic [2:0] div_cnt
);

  // Reload value for the extra-cycle counter; 0 when DIV_CYCLES is 1, so a
  // divide then flows like any other op.
  localparam logic [2:0] DIV_INIT = 3'(DIV_CYCLES - 1);

  // A stage matches a register only if that stage actually writes it.
  function automatic logic hit(input logic w, input logic [4:0] n, input logic [4:0] r);
    return w & (n == r);
  endfunction

  logic [4:0] e1n_r, e2n_r, e3n_r, wn_r;
  logic       e1w_r, e2w_r, e3w_r, ww_r;
  logic [2:0] div_cnt_r;

  logic chk_a_s, chk_b_s;
  logic stl_fp_s, stl_div_s, stl_s;
  logic fwdfa_s, fwdfb_s;
  logic issue_s, is_div_s;

  // Hazard compare, stall and forwarding decode against the current stages.
  // A W-stage match needs no action because the regfile writes through.
  always_comb begin
    chk_a_s   = id_valid & id_use_fs;
    chk_b_s   = id_valid & id_use_ft;
    stl_fp_s  = (chk_a_s & (hit(e1w_r, e1n_r, id_fs) | hit(e2w_r, e2n_r, id_fs))) |
                (chk_b_s & (hit(e1w_r, e1n_r, id_ft) | hit(e2w_r, e2n_r, id_ft)));
    stl_div_s = (div_cnt_r != 3'd0);
    stl_s     = stl_fp_s | stl_div_s;
    fwdfa_s   = chk_a_s & hit(e3w_r, e3n_r, id_fs) & ~stl_fp_s;
    fwdfb_s   = chk_b_s & hit(e3w_r, e3n_r, id_ft) & ~stl_fp_s;
    issue_s   = id_valid & ~stl_s;
    is_div_s  = (id_fc == FC_DIV) | (id_fc == FC_SQRT);
  end

  // Stage advance. While the divider is busy, E1 is frozen, E2 takes a
  // bubble and E3/W keep draining.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e1n_r     <= 5'd0;
      e2n_r     <= 5'd0;
      e3n_r     <= 5'd0;
      wn_r      <= 5'd0;
      e1w_r     <= 1'b0;
      e2w_r     <= 1'b0;
      e3w_r     <= 1'b0;
      ww_r      <= 1'b0;
      div_cnt_r <= 3'd0;
    end else if (div_cnt_r == 3'd0) begin
      wn_r  <= e3n_r;
      ww_r  <= e3w_r;
      e3n_r <= e2n_r;
      e3w_r <= e2w_r;
      e2n_r <= e1n_r;
      e2w_r <= e1w_r;
      if (issue_s) begin
        e1n_r <= id_fd;
        e1w_r <= id_wf;
        if (is_div_s) begin
          div_cnt_r <= DIV_INIT;
        end else begin
          div_cnt_r <= 3'd0;
        end
      end else begin
        e1n_r     <= 5'd0;
        e1w_r     <= 1'b0;
        div_cnt_r <= 3'd0;
      end
    end else begin
      wn_r      <= e3n_r;
      ww_r      <= e3w_r;
      e3n_r     <= e2n_r;
      e3w_r     <= e2w_r;
      e2n_r     <= 5'd0;
      e2w_r     <= 1'b0;
      div_cnt_r <= div_cnt_r - 3'd1;
    end
  end

  assign e1n     = e1n_r;
  assign e2n     = e2n_r;
  assign e3n     = e3n_r;
  assign wn      = wn_r;
  assign e1w     = e1w_r;
  assign e2w     = e2w_r;
  assign e3w     = e3w_r;
  assign ww      = ww_r;
  assign div_cnt = div_cnt_r;
  assign stl_fp  = stl_fp_s;
  assign stl_div = stl_div_s;
  assign stl     = stl_s;
  assign fwdfa   = fwdfa_s;
  assign fwdfb   = fwdfb_s;

endmodule

// File: tb/tb_fp_pipe_scoreboard.sv
// Directed testbench for fp_pipe_scoreboard (DIV_CYCLES = 4).
// Inputs change 1 time unit after each rising edge. Outputs are sampled on
// the falling edge. "Cycle k" is the interval after the k-th rising edge
// following the first instruction's presentation.
module tb_fp_pipe_scoreboard;

  logic       clk = 1'b0;
  logic       clrn;
  logic       id_valid;
  logic [2:0] id_fc;
  logic [4:0] id_fs, id_ft, id_fd;
  logic       id_use_fs, id_use_ft, id_wf;
  logic [4:0] e1n, e2n, e3n, wn;
  logic       e1w, e2w, e3w, ww;
  logic       fwdfa, fwdfb, stl_fp, stl_div, stl;
  logic [2:0] div_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  fp_pipe_scoreboard #(.DIV_CYCLES(4), .FC_DIV(3'b011), .FC_SQRT(3'b111)) dut (
    .clk(clk), .clrn(clrn),
    .id_valid(id_valid), .id_fc(id_fc), .id_fs(id_fs), .id_ft(id_ft),
    .id_use_fs(id_use_fs), .id_use_ft(id_use_ft), .id_fd(id_fd), .id_wf(id_wf),
    .e1n(e1n), .e2n(e2n), .e3n(e3n), .wn(wn),
    .e1w(e1w), .e2w(e2w), .e3w(e3w), .ww(ww),
    .fwdfa(fwdfa), .fwdfb(fwdfb), .stl_fp(stl_fp), .stl_div(stl_div), .stl(stl),
    .div_cnt(div_cnt)
  );

  always #5 clk = ~clk;

  // Every output concatenated: 20+4+5+3 = 32 bits.
  wire [31:0] all_out = {e1n, e2n, e3n, wn, e1w, e2w, e3w, ww,
                         fwdfa, fwdfb, stl_fp, stl_div, stl, div_cnt};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic drive(input logic [2:0] fc, input logic [4:0] fs, input logic [4:0] ft,
                       input logic ufs, input logic uft, input logic [4:0] fd, input logic wf);
    id_valid  = 1'b1;
    id_fc     = fc;
    id_fs     = fs;
    id_ft     = ft;
    id_use_fs = ufs;
    id_use_ft = uft;
    id_fd     = fd;
    id_wf     = wf;
  endtask

  task automatic idle();
    id_valid  = 1'b0;
    id_fc     = 3'd0;
    id_fs     = 5'd0;
    id_ft     = 5'd0;
    id_use_fs = 1'b0;
    id_use_ft = 1'b0;
    id_fd     = 5'd0;
    id_wf     = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    clrn = 1'b0;
    idle();
    #12;
    chk("reset_outputs", all_out, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (5) next_cycle();
    sample();
    chk("idle_outputs", all_out, 32'd0);

    // Independent stream: add f2, mul f3, sub f4.
    next_cycle();
    drive(3'b000, 5'd10, 5'd11, 1'b1, 1'b1, 5'd2, 1'b1);
    sample(); chk("ind_stl_c0", {31'd0, stl}, 32'd0);
    next_cycle();
    drive(3'b010, 5'd12, 5'd13, 1'b1, 1'b1, 5'd3, 1'b1);
    sample(); chk("ind_stl_c1", {31'd0, stl}, 32'd0);
    next_cycle();
    drive(3'b001, 5'd14, 5'd15, 1'b1, 1'b1, 5'd4, 1'b1);
    sample(); chk("ind_stl_c2", {31'd0, stl}, 32'd0);
    next_cycle();
    idle();
    sample();
    chk("ind_c3_names", {17'd0, e3n, e2n, e1n}, {17'd0, 5'd2, 5'd3, 5'd4});
    chk("ind_c3_wen", {29'd0, e3w, e2w, e1w}, 32'd7);
    next_cycle();
    sample();
    chk("ind_c4_w", {26'd0, ww, wn}, {26'd0, 1'b1, 5'd2});
    repeat (4) next_cycle();

    // Read-after-write on fs: stall 2 cycles, then forward from E3.
    drive(3'b000, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1);
    next_cycle();
    drive(3'b010, 5'd5, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1);
    sample(); chk("raw_stl_c1", {30'd0, stl_fp, stl}, 32'd3);
    next_cycle();
    sample(); chk("raw_stl_c2", {30'd0, stl_fp, stl}, 32'd3);
    next_cycle();
    sample();
    chk("raw_c3_fwd", {29'd0, stl_fp, fwdfa, fwdfb}, {29'd0, 1'b0, 1'b1, 1'b0});
    chk("raw_c3_e3n", {27'd0, e3n}, {27'd0, 5'd5});
    next_cycle();
    idle();
    sample();
    chk("raw_issued", {26'd0, e1w, e1n}, {26'd0, 1'b1, 5'd10});
    repeat (4) next_cycle();

    // f0 is an ordinary register.
    drive(3'b000, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b1);
    next_cycle();
    drive(3'b000, 5'd0, 5'd7, 1'b1, 1'b1, 5'd1, 1'b1);
    sample(); chk("f0_hazard", {31'd0, stl_fp}, 32'd1);
    idle();
    repeat (5) next_cycle();

    // Divide: fdiv f6 holds E1 for 4 cycles; the independent add waits.
    drive(3'b011, 5'd20, 5'd21, 1'b1, 1'b1, 5'd6, 1'b1);
    sample(); chk("div_c0_stl", {31'd0, stl}, 32'd0);
    next_cycle();
    drive(3'b000, 5'd22, 5'd23, 1'b1, 1'b1, 5'd7, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      sample();
      chk($sformatf("div_cnt_c%0d", i), {29'd0, div_cnt}, 32'(4 - i));
      chk($sformatf("div_flags_c%0d", i), {29'd0, stl_div, stl_fp, stl}, 32'b101);
      chk($sformatf("div_e1_c%0d", i), {25'd0, e1w, e1n, e2w}, {25'd0, 1'b1, 5'd6, 1'b0});
      next_cycle();
    end
    sample();
    chk("div_c4_free", {27'd0, div_cnt, stl_div, stl}, 32'd0);
    next_cycle();
    idle();
    sample();
    chk("div_c5_stages", {22'd0, e1n, e2n}, {22'd0, 5'd7, 5'd6});
    next_cycle();
    sample(); chk("div_c6_e3n", {27'd0, e3n}, {27'd0, 5'd6});
    next_cycle();
    sample(); chk("div_c7_w", {26'd0, ww, wn}, {26'd0, 1'b1, 5'd6});
    repeat (4) next_cycle();

    // fsqrt f12 with a dependent reader: both stall causes are flagged.
    drive(3'b111, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1);
    next_cycle();
    drive(3'b000, 5'd12, 5'd3, 1'b1, 1'b1, 5'd13, 1'b1);
    sample();
    chk("sqrt_both", {28'd0, div_cnt, stl_fp, stl_div, stl}, {25'd0, 3'd3, 1'b1, 1'b1, 1'b1});
    idle();
    repeat (8) next_cycle();

    // swc1-style hazard on ft against E2, forwarded from E3 next cycle.
    drive(3'b000, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1);
    next_cycle();
    idle();
    next_cycle();
    drive(3'b000, 5'd0, 5'd8, 1'b0, 1'b1, 5'd0, 1'b0);
    sample();
    chk("swc1_e2", {26'd0, e2w, e2n}, {26'd0, 1'b1, 5'd8});
    chk("swc1_stl", {31'd0, stl_fp}, 32'd1);
    next_cycle();
    sample();
    chk("swc1_fwd", {29'd0, stl_fp, fwdfa, fwdfb}, 32'b001);
    next_cycle();
    idle();
    repeat (4) next_cycle();

    // A non-writing op to f8 must not stall a reader of f8.
    drive(3'b000, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0);
    next_cycle();
    drive(3'b000, 5'd0, 5'd8, 1'b0, 1'b1, 5'd0, 1'b0);
    sample();
    chk("nowf_e1", {26'd0, e1w, e1n}, {26'd0, 1'b0, 5'd8});
    chk("nowf_stl", {31'd0, stl}, 32'd0);
    next_cycle();
    idle();
    repeat (4) next_cycle();

    // Reset mid-divide clears everything asynchronously.
    drive(3'b011, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1);
    next_cycle();
    idle();
    next_cycle();
    sample();
    chk("rstdiv_cnt", {29'd0, div_cnt}, 32'd2);
    #2;
    clrn = 1'b0;
    #1;
    chk("rstdiv_async", all_out, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    next_cycle();
    drive(3'b000, 5'd9, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1);
    sample();
    chk("rstdiv_nostl", {31'd0, stl}, 32'd0);
    next_cycle();
    idle();
    sample();
    chk("rstdiv_issue", {23'd0, e1w, e1n, div_cnt}, {23'd0, 1'b1, 5'd11, 3'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
